// File: rtl/fsk_zc_demod_pkg.sv
// Shared tone encoding and default rate parameters for the FSK modulator/demodulator pair.
package fsk_zc_demod_pkg;

  localparam logic TONE0 = 1'b0;
  localparam logic TONE1 = 1'b1;

  // 20 kbaud at 50 MHz; tones at 100/200 kHz give half-periods of 250/125 cycles
  localparam int SPS_DEF    = 2500;
  localparam int THRESH_DEF = 188;

endpackage

// File: rtl/fsk_zc_slicer.sv
// Input register plus hysteresis sign slicer; pulses zc on the cycle the sign state flips.
module fsk_zc_slicer #(
  parameter int DATA_W = 16,
  parameter int HYST   = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] fir_out,
  output logic              zc
);

  localparam logic signed [DATA_W:0] HYST_P = (DATA_W+1)'(HYST);
  localparam logic signed [DATA_W:0] HYST_N = -HYST_P;

  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W:0]   x_ext;
  logic                     sign_q;
  logic                     sign_next;

  assign x_ext = {x_r[DATA_W-1], x_r};

  always_comb begin
    sign_next = sign_q;
    if (x_ext > HYST_P)
      sign_next = 1'b1;
    else if (x_ext < HYST_N)
      sign_next = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_r    <= '0;
      sign_q <= 1'b0;
      zc     <= 1'b0;
    end else begin
      x_r    <= $signed(fir_out);
      sign_q <= sign_next;
      zc     <= (sign_next != sign_q);
    end
  end

endmodule

// File: rtl/fsk_zc_demod.sv
// Zero-crossing FSK demodulator: half-period measurement, tone slicing, symbol timing
// recovery and lock detection on top of the hysteresis slicer.
module fsk_zc_demod
  import fsk_zc_demod_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int HYST      = 256,
  parameter int CNT_W     = 12,
  parameter int THRESH    = THRESH_DEF,
  parameter int SPS       = SPS_DEF,
  parameter int LOCK_SYMS = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] fir_out,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [CNT_W-1:0]  half_period,
  output logic              carrier_ok,
  output logic              sync_lock
);

  localparam int SYM_W  = $clog2(SPS);
  localparam int LOCK_W = $clog2(LOCK_SYMS + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]    THRESH_C = (CNT_W+1)'(THRESH);
  localparam logic [SYM_W-1:0]  SYM_MID  = SYM_W'(SPS / 2);
  localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(SPS - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_SYMS);

  logic              zc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    meas;
  logic [CNT_W-1:0]  meas_sat;
  logic              meas_ok;
  logic              tone;
  logic              tone_dec;
  logic              tone_next;
  logic              tone_chg;
  logic              strobe;
  logic [SYM_W-1:0]  sym_cnt;
  logic [LOCK_W-1:0] lock_cnt;

  fsk_zc_slicer #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_slicer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .fir_out   (fir_out),
    .zc        (zc)
  );

  assign meas     = {1'b0, count} + (CNT_W+1)'(1);
  assign meas_sat = meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
  assign tone_dec = (meas < THRESH_C) ? TONE1 : TONE0;

  // meas_ok gates out the partial interval that precedes the first crossing
  always_comb begin
    tone_next = tone;
    if (zc && meas_ok)
      tone_next = tone_dec;
  end

  assign tone_chg = (tone_next != tone);
  assign strobe   = !tone_chg && (sym_cnt == SYM_MID) && carrier_ok;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count       <= '0;
      half_period <= '0;
      carrier_ok  <= 1'b0;
      meas_ok     <= 1'b0;
      tone        <= TONE0;
    end else begin
      tone <= tone_next;
      if (zc) begin
        half_period <= meas_sat;
        count       <= '0;
        carrier_ok  <= 1'b1;
        meas_ok     <= 1'b1;
      end else if (count == CNT_MAX) begin
        carrier_ok <= 1'b0;
        meas_ok    <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // A tone change realigns the symbol grid, so the next decision lands mid-symbol
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sym_cnt   <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
    end else begin
      if (tone_chg || sym_cnt == SYM_LAST)
        sym_cnt <= '0;
      else
        sym_cnt <= sym_cnt + 1'b1;
      bit_valid <= strobe;
      if (strobe)
        bit_out <= tone;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_cnt  <= '0;
      sync_lock <= 1'b0;
    end else if (!carrier_ok) begin
      lock_cnt  <= '0;
      sync_lock <= 1'b0;
    end else if (strobe && lock_cnt != LOCK_MAX) begin
      lock_cnt  <= lock_cnt + 1'b1;
      sync_lock <= ((lock_cnt + 1'b1) == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_fsk_zc_demod.sv
// Directed bench for fsk_zc_demod with SPS=40, THRESH=6, HYST=256, CNT_W=6, LOCK_SYMS=4.
module tb_fsk_zc_demod;

  localparam int AMP = 1000;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [15:0] fir_out;
  logic        bit_out;
  logic        bit_valid;
  logic [5:0]  half_period;
  logic        carrier_ok;
  logic        sync_lock;

  int   checks;
  int   errors;
  int   cyc;
  bit   pol;
  int   lock_rise;
  int   st_t[$];
  logic st_b[$];

  fsk_zc_demod #(
    .DATA_W    (16),
    .HYST      (256),
    .CNT_W     (6),
    .THRESH    (6),
    .SPS       (40),
    .LOCK_SYMS (4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .fir_out     (fir_out),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .half_period (half_period),
    .carrier_ok  (carrier_ok),
    .sync_lock   (sync_lock)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One sample per call; observations reflect the state just after that sample's edge
  task automatic step(input int v);
    fir_out = v[15:0];
    @(posedge sys_clk);
    #1;
    if (bit_valid === 1'b1) begin
      st_t.push_back(cyc);
      st_b.push_back(bit_out);
    end
    if (sync_lock === 1'b1 && lock_rise < 0)
      lock_rise = cyc;
    cyc++;
  endtask

  task automatic run_wave(input int half, input int nhalves);
    for (int h = 0; h < nhalves; h++) begin
      pol = ~pol;
      for (int k = 0; k < half; k++)
        step(pol ? AMP : -AMP);
    end
  endtask

  task automatic clear_log();
    st_t.delete();
    st_b.delete();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(int'($urandom_range(0, 65535)));
      checks++;
      if ({bit_out, bit_valid, half_period, carrier_ok, sync_lock} !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold: outputs=%b required 0", {bit_out, bit_valid, half_period, carrier_ok, sync_lock});
      end
    end
    fir_out   = 16'd0;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0);
      checks++;
      if ({bit_out, bit_valid, half_period, carrier_ok, sync_lock} !== 10'd0) begin
        errors++;
        $display("FAIL reset_release: outputs=%b required 0", {bit_out, bit_valid, half_period, carrier_ok, sync_lock});
      end
    end
  endtask

  task automatic test_tone1();
    int s0;
    int n;
    s0 = cyc;
    pol = 1'b0;
    clear_log();
    run_wave(4, 50);
    n = 0;
    for (int i = 0; i < st_t.size(); i++) begin
      if (st_t[i] >= s0 + 7) begin
        checks++;
        if (st_t[i] != s0 + 27 + 40 * n) begin
          errors++;
          $display("FAIL tone1_strobe_time[%0d]: got %0d required %0d", n, st_t[i] - s0, 27 + 40 * n);
        end
        checks++;
        if (st_b[i] !== 1'b1) begin
          errors++;
          $display("FAIL tone1_bit[%0d]: got %b required 1", n, st_b[i]);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL tone1_strobe_count: got %0d required 5", n);
    end
    checks++;
    if (half_period !== 6'd4) begin
      errors++;
      $display("FAIL tone1_half_period: got %0d required 4", half_period);
    end
  endtask

  task automatic test_alternate();
    int s;
    int n;
    int exp_t[4];
    logic exp_b[4];
    exp_t = '{31, 71, 107, 147};
    exp_b = '{1'b0, 1'b0, 1'b1, 1'b1};
    s = cyc;
    clear_log();
    run_wave(8, 10);
    run_wave(4, 20);
    n = 0;
    for (int i = 0; i < st_t.size(); i++) begin
      if (st_t[i] >= s + 11) begin
        if (n < 4) begin
          checks++;
          if (st_t[i] != s + exp_t[n]) begin
            errors++;
            $display("FAIL alt_strobe_time[%0d]: got %0d required %0d", n, st_t[i] - s, exp_t[n]);
          end
          checks++;
          if (st_b[i] !== exp_b[n]) begin
            errors++;
            $display("FAIL alt_bit[%0d]: got %b required %b", n, st_b[i], exp_b[n]);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL alt_strobe_count: got %0d required 4", n);
    end
  endtask

  task automatic test_no_carrier();
    int t4;
    int stray;
    t4 = cyc;
    stray = 0;
    for (int i = 0; i < 150; i++) begin
      step(((i / 4) % 2 == 1) ? -200 : 200);
      if (i == 61) begin
        checks++;
        if (carrier_ok !== 1'b1) begin
          errors++;
          $display("FAIL nocar_before_sat: carrier_ok=%b required 1", carrier_ok);
        end
      end
      if (i == 62) begin
        checks++;
        if (carrier_ok !== 1'b0) begin
          errors++;
          $display("FAIL nocar_at_sat: carrier_ok=%b required 0", carrier_ok);
        end
      end
      if (i >= 62 && bit_valid !== 1'b0)
        stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL nocar_strobes: got %0d strobes required 0", stray);
    end
    checks++;
    if (sync_lock !== 1'b0 || carrier_ok !== 1'b0) begin
      errors++;
      $display("FAIL nocar_final: sync_lock=%b carrier_ok=%b required 0 0", sync_lock, carrier_ok);
    end
    checks++;
    if (half_period !== 6'd4) begin
      errors++;
      $display("FAIL nocar_half_period: got %0d required 4", half_period);
    end
    if (cyc != t4 + 150) $display("note: unexpected cycle bookkeeping");
  endtask

  task automatic test_lock();
    int t5;
    int n;
    int drop;
    t5 = cyc;
    clear_log();
    lock_rise = -1;
    run_wave(8, 20);
    n = 0;
    for (int i = 0; i < st_t.size(); i++) begin
      if (n < 4) begin
        checks++;
        if (st_t[i] != t5 + 31 + 40 * n || st_b[i] !== 1'b0) begin
          errors++;
          $display("FAIL lock_strobe[%0d]: time %0d bit %b required time %0d bit 0", n, st_t[i] - t5, st_b[i], 31 + 40 * n);
        end
      end
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL lock_strobe_count: got %0d required 4", n);
    end
    checks++;
    if (lock_rise != t5 + 151) begin
      errors++;
      $display("FAIL lock_rise: got %0d required %0d", lock_rise - t5, 151);
    end
    drop = -1;
    for (int i = 0; i < 120 && drop < 0; i++) begin
      step(0);
      if (carrier_ok === 1'b0) begin
        drop = cyc - 1;
        checks++;
        if (sync_lock !== 1'b1) begin
          errors++;
          $display("FAIL lock_hold_at_drop: sync_lock=%b required 1", sync_lock);
        end
      end
    end
    checks++;
    if (drop != t5 + 218) begin
      errors++;
      $display("FAIL lock_carrier_drop: at %0d required %0d", drop - t5, 218);
    end
    step(0);
    checks++;
    if (sync_lock !== 1'b0) begin
      errors++;
      $display("FAIL lock_clear: sync_lock=%b required 0", sync_lock);
    end
  endtask

  task automatic test_reset_mid_symbol();
    int u;
    clear_log();
    run_wave(4, 5);
    pol = ~pol;
    step(pol ? AMP : -AMP);
    step(pol ? AMP : -AMP);
    checks++;
    if (carrier_ok !== 1'b1 || half_period !== 6'd4 || st_t.size() != 0) begin
      errors++;
      $display("FAIL mid_pre_reset: carrier_ok=%b half_period=%0d strobes=%0d required 1 4 0", carrier_ok, half_period, st_t.size());
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bit_out, bit_valid, half_period, carrier_ok, sync_lock} !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_immediate: outputs=%b required 0", {bit_out, bit_valid, half_period, carrier_ok, sync_lock});
    end
    for (int i = 0; i < 3; i++)
      step(0);
    checks++;
    if ({bit_out, bit_valid, half_period, carrier_ok, sync_lock} !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_hold: outputs=%b required 0", {bit_out, bit_valid, half_period, carrier_ok, sync_lock});
    end
    sys_rst_n = 1'b1;
    pol = 1'b0;
    clear_log();
    u = cyc;
    run_wave(4, 20);
    checks++;
    if (st_t.size() != 2) begin
      errors++;
      $display("FAIL mid_reacq_count: got %0d strobes required 2", st_t.size());
    end else begin
      checks++;
      if (st_t[0] != u + 27 || st_b[0] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reacq_first: time %0d bit %b required time 27 bit 1", st_t[0] - u, st_b[0]);
      end
      checks++;
      if (st_t[1] != u + 67 || st_b[1] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reacq_second: time %0d bit %b required time 67 bit 1", st_t[1] - u, st_b[1]);
      end
    end
    checks++;
    if (half_period !== 6'd4) begin
      errors++;
      $display("FAIL mid_reacq_half_period: got %0d required 4", half_period);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    pol       = 1'b0;
    lock_rise = -1;
    fir_out   = 16'd0;
    sys_rst_n = 1'b0;
    test_reset();
    test_tone1();
    test_alternate();
    test_no_carrier();
    test_lock();
    test_reset_mid_symbol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
